if_fetch: RTL

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch_pkg.sv | 33 +++
 rtl/if_fetch_fifo.sv | 49 ++++
 rtl/if_fetch.sv | 110 +++++++++++
 3 files changed

// File: rtl/if_fetch_pkg.sv
// Shared fetch-unit definitions: FSM encoding,
// buffer bounds, PC step and buffer entry layout.
package if_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_DROP = 2'b10
  } fetch_state_t;

  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 8;

  localparam logic [31:0] PC_INC = 32'd4;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return a & 32'hFFFF_FFFC;
  endfunction

  function automatic int clamp_depth(input int d);
    if (d < DEPTH_MIN) return DEPTH_MIN;
    if (d > DEPTH_MAX) return DEPTH_MAX;
    return d;
  endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// Instruction buffer between fetch and decode:
// circular store of {word, pc} with flush.
module fetch_fifo
  import if_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wdata,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int k = 0; k < DEPTH; k++)
        mem[k] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/if_fetch.sv
// Fetch stage: one outstanding imem read at a time,
// results queued for decode, redirects flush and retarget.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int D  = clamp_depth(DEPTH);
  localparam int CW = $clog2(D) + 1;
  localparam logic [CW-1:0] FULL = CW'(D);

  fetch_state_t  state_q;
  fetch_state_t  state_d;
  logic [31:0]   fpc_q;
  logic [31:0]   drop_addr_q;
  logic [CW-1:0] count;
  logic          full;
  logic          push;
  logic          pop;
  fetch_entry_t  wdata;
  fetch_entry_t  head;

  assign full = !(count < FULL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (!redirect && !full) state_d = S_WAIT;
      S_WAIT:
        if (imem_ack)      state_d = S_IDLE;
        else if (redirect) state_d = S_DROP;
      S_DROP:
        if (imem_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A dropped request keeps presenting its original address
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = fpc_q;
    unique case (1'b1)
      (state_q == S_WAIT): imem_req = 1'b1;
      (state_q == S_DROP): begin
        imem_req  = 1'b1;
        imem_addr = drop_addr_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpc_q       <= word_align(RESET_PC);
      drop_addr_q <= '0;
    end else if (redirect) begin
      fpc_q <= word_align(redirect_pc);
      if (state_q == S_WAIT)
        drop_addr_q <= fpc_q;
    end else if (push) begin
      fpc_q <= fpc_q + PC_INC;
    end
  end

  assign push = (state_q == S_WAIT) && imem_ack
             && !redirect;
  assign pop  = inst_valid && inst_ready && !redirect;

  assign wdata.word = imem_rdata;
  assign wdata.pc   = fpc_q;

  fetch_fifo #(
    .DEPTH (D)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (wdata),
    .head  (head),
    .count (count)
  );

  assign inst_valid = (count != '0);
  assign inst       = head.word;
  assign inst_pc    = head.pc;

endmodule
